// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer_pkg: shared types for the bus sequencer read-data path
package bus_sequencer_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef struct packed {
        logic [2:0]  nbytes;
        logic [31:0] data;
    } rdata_word_t;
endpackage

// File: rtl/bus_seq_sync_fifo.sv
// bus_seq_sync_fifo: single-clock first-word-fall-through FIFO with level
module bus_seq_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    always_comb begin
        full    = level == (AW+1)'(DEPTH);
        empty   = level == '0;
        do_pop  = pop && !empty;
        // a full FIFO still accepts a write when the head leaves in the same cycle
        do_push = push && (!full || do_pop);
        rdata   = empty ? '0 : mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/bus_seq_rdata_packer.sv
// bus_seq_rdata_packer: packs sequencer read bytes into 32-bit words behind a FWFT FIFO
module bus_seq_rdata_packer
    import bus_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter     BYTE_ORDER = "LSB_FIRST"
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic [7:0]                    bus_data_i,
    input  logic                          bus_data_valid_i,
    input  logic                          seq_ready_i,
    input  logic                          clear_i,
    output logic [31:0]                   word_o,
    output logic [2:0]                    word_nbytes_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
);
    localparam bit LSB = BYTE_ORDER == "LSB_FIRST";
    logic        clr, prev_ready, overflow, flush, push, full, empty;
    logic [1:0]  count, lane;
    logic [2:0]  new_cnt;
    logic [23:0] hold;
    logic [31:0] held, merged;
    rdata_word_t push_word, head;
    always_comb begin
        clr       = !nrst_i || clear_i;
        held      = LSB ? {8'h00, hold} : {hold, 8'h00};
        lane      = LSB ? count : 2'd3 - count;
        merged    = held | (bus_data_valid_i ? {24'h0, bus_data_i} << {lane, 3'b000} : 32'h0);
        new_cnt   = {1'b0, count} + {2'b00, bus_data_valid_i};
        flush     = seq_ready_i && !prev_ready;
        // a same-cycle byte is counted before deciding, so a completing byte yields one push
        push      = new_cnt == 3'(BYTES_PER_WORD) || (flush && new_cnt != 3'd0);
        push_word = '{nbytes: new_cnt, data: merged};
    end
    always_ff @(posedge clk_i) begin
        if (clr) begin
            count      <= '0;
            hold       <= '0;
            prev_ready <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            prev_ready <= seq_ready_i;
            if (push) begin
                count <= '0;
                hold  <= '0;
            end else if (bus_data_valid_i) begin
                count <= new_cnt[1:0];
                hold  <= LSB ? merged[23:0] : merged[31:8];
            end
            if (push && full && !word_ready_i)
                overflow <= 1'b1;
        end
    end
    bus_seq_sync_fifo #(.WIDTH($bits(rdata_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (clr),
        .push  (push && !clr),
        .wdata (push_word),
        .pop   (word_ready_i),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );
    assign word_o        = head.data;
    assign word_nbytes_o = head.nbytes;
    assign word_valid_o  = !empty;
    assign overflow_o    = overflow;
endmodule

// File: tb/tb_bus_seq_rdata_packer.sv
// tb_bus_seq_rdata_packer: directed bench with a queue-based model for both byte orders
module tb_bus_seq_rdata_packer;
    logic       clk = 0, nrst = 0, valid = 0, sready = 1, clear = 0, wready = 0;
    logic [7:0] bdata = 0;
    logic [31:0] wl, wm;
    logic [2:0]  nbl, nbm;
    logic        vl, vm, ovl, ovm;
    logic [3:0]  levl, levm;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    bus_seq_rdata_packer #(.FIFO_DEPTH(8), .BYTE_ORDER("LSB_FIRST")) dut_l (
        .clk_i(clk), .nrst_i(nrst), .bus_data_i(bdata), .bus_data_valid_i(valid),
        .seq_ready_i(sready), .clear_i(clear), .word_o(wl), .word_nbytes_o(nbl),
        .word_valid_o(vl), .word_ready_i(wready), .level_o(levl), .overflow_o(ovl));
    bus_seq_rdata_packer #(.FIFO_DEPTH(8), .BYTE_ORDER("MSB_FIRST")) dut_m (
        .clk_i(clk), .nrst_i(nrst), .bus_data_i(bdata), .bus_data_valid_i(valid),
        .seq_ready_i(sready), .clear_i(clear), .word_o(wm), .word_nbytes_o(nbm),
        .word_valid_o(vm), .word_ready_i(wready), .level_o(levm), .overflow_o(ovm));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // model: pending bytes in arrival order, words held in LSB_FIRST layout
    logic [7:0]  pend[$];
    logic [34:0] mq[$];
    bit          m_ovf = 0, m_prev = 1;

    always @(posedge clk) begin
        logic [31:0] d;
        bit pop_ok, cand;
        int presz;
        if (!nrst || clear) begin
            pend.delete();
            mq.delete();
            m_ovf = 0;
            m_prev = 1;
        end else begin
            presz = mq.size();
            pop_ok = wready && presz > 0;
            if (valid) pend.push_back(bdata);
            cand = pend.size() == 4 || (sready && !m_prev && pend.size() > 0);
            m_prev = sready;
            if (pop_ok) void'(mq.pop_front());
            if (cand) begin
                d = 0;
                foreach (pend[i]) d[8*i +: 8] = pend[i];
                if (presz == 8 && !pop_ok) m_ovf = 1;
                else mq.push_back({3'(pend.size()), d});
                pend.delete();
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ew;
        logic [2:0]  en;
        ew = mq.size() > 0 ? mq[0][31:0] : 32'h0;
        en = mq.size() > 0 ? mq[0][34:32] : 3'h0;
        check("l_word", wl, ew);
        check("l_nbytes", nbl, en);
        check("l_valid", vl, mq.size() > 0);
        check("l_level", levl, mq.size());
        check("l_ovf", ovl, m_ovf);
        check("m_word", wm, bswap(ew));
        check("m_nbytes", nbm, en);
        check("m_valid", vm, mq.size() > 0);
        check("m_level", levm, mq.size());
        check("m_ovf", ovm, m_ovf);
    end

    task automatic put(input logic v, input logic [7:0] d, input logic r, input logic p);
        valid = v;
        bdata = d;
        sready = r;
        wready = p;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", vl, 0);
        check("rst_level", levl, 0);
        check("rst_ovf", ovl, 0);
        check("rst_word", wl, 0);
        check("rst_nbytes", nbl, 0);
        nrst = 1;
        // full word, both byte orders
        put(1, 8'h11, 0, 0); put(1, 8'h22, 0, 0); put(1, 8'h33, 0, 0); put(1, 8'h44, 0, 0);
        check("t1_valid", vl, 1);
        check("t1_word", wl, 32'h44332211);
        check("t1_nbytes", nbl, 4);
        check("t1_level", levl, 1);
        check("t1_mword", wm, 32'h11223344);
        put(0, 0, 0, 1);
        check("t1_popped", levl, 0);
        // six bytes then flush
        put(1, 8'h11, 0, 0); put(1, 8'h22, 0, 0); put(1, 8'h33, 0, 0);
        put(1, 8'h44, 0, 0); put(1, 8'h55, 0, 0); put(1, 8'h66, 0, 0);
        put(0, 0, 1, 0);
        check("t2_level", levl, 2);
        check("t2_word0", wl, 32'h44332211);
        put(0, 0, 1, 1);
        check("t2_word1", wl, 32'h00006655);
        check("t2_nbytes1", nbl, 2);
        check("t2_mword1", wm, 32'h55660000);
        put(0, 0, 1, 1);
        put(0, 0, 0, 0);
        put(0, 0, 1, 0);
        check("t2_no_flush", levl, 0);
        check("t2_no_valid", vl, 0);
        // flush coinciding with completing byte
        put(1, 8'hAA, 0, 0); put(1, 8'hBB, 0, 0); put(1, 8'hCC, 0, 0);
        put(1, 8'hDD, 1, 0);
        check("t3_mword", wm, 32'hAABBCCDD);
        check("t3_mnbytes", nbm, 4);
        check("t3_mlevel", levm, 1);
        check("t3_lword", wl, 32'hDDCCBBAA);
        put(0, 0, 1, 1);
        put(0, 0, 0, 0);
        check("t3_single", levl, 0);
        // overflow
        for (int k = 0; k < 9; k++)
            for (int j = 0; j < 4; j++) put(1, 8'(k*16 + j), 0, 0);
        check("t4_level", levl, 8);
        check("t4_ovf", ovl, 1);
        check("t4_head", wl, 32'h03020100);
        repeat (7) put(0, 0, 0, 1);
        check("t4_head8", wl, 32'h73727170);
        check("t4_sticky", ovl, 1);
        clear = 1;
        put(0, 0, 0, 0);
        clear = 0;
        check("t4_clr_level", levl, 0);
        check("t4_clr_ovf", ovl, 0);
        check("t4_clr_valid", vl, 0);
        // push into full FIFO with simultaneous pop
        for (int k = 0; k < 9; k++)
            for (int j = 0; j < 4; j++)
                put(1, 8'(k*16 + j) ^ 8'h5A, 0, (k == 8 && j == 3) ? 1'b1 : 1'b0);
        put(0, 0, 0, 0);
        check("t5_ovf", ovl, 0);
        check("t5_level", levl, 8);
        repeat (7) put(0, 0, 0, 1);
        check("t5_last", wl, 32'hD9D8DBDA);
        put(0, 0, 0, 1);
        check("t5_empty", levl, 0);
        // reset discards partial word
        put(1, 8'h01, 0, 0); put(1, 8'h02, 0, 0);
        nrst = 0;
        put(0, 0, 0, 0);
        nrst = 1;
        put(0, 0, 1, 0);
        put(0, 0, 1, 0);
        check("t6_valid", vl, 0);
        check("t6_level", levl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
